// File: rtl/oci_dct_sequencer.sv
// oci_dct_sequencer: round-robin packs 3-bit addr/data trace symbols into a 30-bit frame and sequences end-of-test drain.
// Latency: an accepted symbol appears in dct_buffer/dct_count after 1 cycle; a frame is valid the cycle after the 10th accept.
// Backpressure: both symbol readies drop while a frame waits on frame_ready, and in DONE; frame contents stay stable until the handshake.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   addr_sym_valid/sym/ready    address-trace symbol source
//   data_sym_valid/sym/ready    data-trace symbol source
//   test_ending                 level request to drain and stop
//   frame_valid/ready/data/count  frame output handshake (count 1..10)
//   dct_buffer, dct_count       live packing register and symbol count
//   test_has_ended              sticky drain-complete flag
module oci_dct_sequencer #(
  parameter int IDLE_FLUSH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_sym_valid,
  input  logic [2:0]  addr_sym,
  output logic        addr_sym_ready,
  input  logic        data_sym_valid,
  input  logic [2:0]  data_sym,
  output logic        data_sym_ready,
  input  logic        test_ending,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             IW        = 16;
  localparam bit             IDLE_EN   = (IDLE_FLUSH != 0);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_FLUSH - 1);

  logic [1:0]    r_state;
  logic [29:0]   r_buf;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_idle;
  logic          r_last_addr;   // 1: last accept came from addr, 0: from data
  logic          r_ending_pend;

  logic          w_arb;
  logic          w_gnt_a;
  logic          w_gnt_d;
  logic          w_acc;
  logic [2:0]    w_sym;
  logic          w_idle_fire;

  // Readies are gated by reset so every output reads 0 while reset is held,
  // even though the state register already sits in FILL.
  assign w_arb   = (r_state == S_FILL) && !test_ending && !reset;
  // On a contest, the source that did not win last time gets the grant.
  assign w_gnt_a = w_arb && addr_sym_valid && (!data_sym_valid || !r_last_addr);
  assign w_gnt_d = w_arb && data_sym_valid && !w_gnt_a;
  assign w_acc   = w_gnt_a || w_gnt_d;
  assign w_sym   = w_gnt_a ? addr_sym : data_sym;

  // Fires on the IDLE_FLUSH-th consecutive non-accepting cycle with data held.
  assign w_idle_fire = IDLE_EN && (r_cnt != 4'd0) && (r_idle == IDLE_LAST) && !w_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FILL;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_idle        <= '0;
      r_last_addr   <= 1'b0;
      r_ending_pend <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (test_ending) begin
            // Ending wins over any symbol offered in the same cycle.
            r_idle <= '0;
            if (r_cnt != 4'd0) begin
              r_state       <= S_EMIT;
              r_ending_pend <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end else if (w_acc) begin
            r_buf       <= {r_buf[26:0], w_sym};
            r_cnt       <= r_cnt + 4'd1;
            r_last_addr <= w_gnt_a;
            r_idle      <= '0;
            if (r_cnt == 4'd9) begin
              r_state <= S_EMIT;
            end
          end else if (w_idle_fire) begin
            r_state <= S_EMIT;
            r_idle  <= '0;
          end else if (r_cnt != 4'd0) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_EMIT: begin
          if (test_ending) begin
            r_ending_pend <= 1'b1;
          end
          if (frame_ready) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_state <= (r_ending_pend || test_ending) ? S_DONE : S_FILL;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign addr_sym_ready = w_gnt_a;
  assign data_sym_ready = w_gnt_d;
  assign frame_valid    = (r_state == S_EMIT);
  assign frame_data     = r_buf;
  assign frame_count    = r_cnt;
  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign test_has_ended = (r_state == S_DONE);

endmodule

// File: tb/tb_oci_dct_sequencer.sv
// tb_oci_dct_sequencer: directed vectors for oci_dct_sequencer with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge, outputs are checked 1-2 units later.
// Backpressure: frame_ready is held low and released explicitly by the stimulus.
module tb_oci_dct_sequencer;

  logic        clk;
  logic        reset;
  logic        addr_sym_valid;
  logic [2:0]  addr_sym;
  logic        addr_sym_ready;
  logic        data_sym_valid;
  logic [2:0]  data_sym;
  logic        data_sym_ready;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int n_vec;
  int n_err;

  oci_dct_sequencer #(.IDLE_FLUSH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr_sym_valid (addr_sym_valid),
    .addr_sym       (addr_sym),
    .addr_sym_ready (addr_sym_ready),
    .data_sym_valid (data_sym_valid),
    .data_sym       (data_sym),
    .data_sym_ready (data_sym_ready),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    addr_sym_valid = 1'b1;
    addr_sym       = 3'd0;
    data_sym_valid = 1'b1;
    data_sym       = 3'd0;
    test_ending    = 1'b0;
    frame_ready    = 1'b0;

    // Reset state: everything 0 even with both sources offering.
    #2;
    chk("rst_addr_rdy", addr_sym_ready, 0);
    chk("rst_data_rdy", data_sym_ready, 0);
    chk("rst_fvalid",   frame_valid, 0);
    chk("rst_count",    dct_count, 0);
    chk("rst_buffer",   dct_buffer, 0);
    chk("rst_ended",    test_has_ended, 0);
    @(negedge clk);
    reset          = 1'b0;
    addr_sym_valid = 1'b0;
    data_sym_valid = 1'b0;
    tick();

    // Both sources always valid: A,D,A,D... starting with addr.
    addr_sym_valid = 1'b1;
    addr_sym       = 3'd5;
    data_sym_valid = 1'b1;
    data_sym       = 3'd2;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_addr_rdy", addr_sym_ready, 32'((k % 2) == 0));
      chk("rr_data_rdy", data_sym_ready, 32'((k % 2) == 1));
      tick();
    end
    chk("rr_fvalid", frame_valid, 1);
    chk("rr_fcount", frame_count, 10);
    chk("rr_fdata",  frame_data, 30'b101_010_101_010_101_010_101_010_101_010);

    // Sink stalls for 20 cycles: frame stable, no source accepted.
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("hold_fdata",    frame_data, 30'b101_010_101_010_101_010_101_010_101_010);
      chk("hold_addr_rdy", addr_sym_ready, 0);
      chk("hold_data_rdy", data_sym_ready, 0);
      tick();
    end
    addr_sym_valid = 1'b0;
    data_sym_valid = 1'b0;
    frame_ready    = 1'b1;
    tick();
    chk("hold_rel_fvalid", frame_valid, 0);
    chk("hold_rel_count",  dct_count, 0);
    frame_ready = 1'b0;

    // Addr only, symbols 1..10 (masked to 3 bits), back to back.
    addr_sym_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      addr_sym = 3'(i);
      #1;
      chk("seq_addr_rdy", addr_sym_ready, 1);
      tick();
    end
    chk("seq_fvalid", frame_valid, 1);
    chk("seq_fcount", frame_count, 10);
    chk("seq_fdata",  frame_data, 30'b001_010_011_100_101_110_111_000_001_010);
    #1;
    chk("seq_emit_rdy", addr_sym_ready, 0);
    addr_sym_valid = 1'b0;
    frame_ready    = 1'b1;
    tick();
    chk("seq_post_count",  dct_count, 0);
    chk("seq_post_buffer", dct_buffer, 0);
    chk("seq_post_fvalid", frame_valid, 0);
    frame_ready = 1'b0;

    // 3 symbols then idle: flush on the 4th idle edge.
    addr_sym_valid = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      addr_sym = 3'(i);
      tick();
    end
    addr_sym_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("idle_fvalid", frame_valid, 32'(j == 4));
    end
    chk("idle_fcount", frame_count, 3);
    chk("idle_fdata",  frame_data, 30'b011_100_101);
    frame_ready = 1'b1;
    tick();
    chk("idle_post_count", dct_count, 0);
    frame_ready = 1'b0;

    // 4 data symbols, then test_ending with a symbol offered.
    data_sym_valid = 1'b1;
    data_sym = 3'd6; #1; chk("end_data_rdy", data_sym_ready, 1); tick();
    data_sym = 3'd7; tick();
    data_sym = 3'd1; tick();
    data_sym = 3'd2; tick();
    data_sym    = 3'd3;
    test_ending = 1'b1;
    #1;
    chk("end_blocked_rdy", data_sym_ready, 0);
    tick();
    test_ending    = 1'b0;
    data_sym_valid = 1'b0;
    chk("end_fvalid", frame_valid, 1);
    chk("end_fcount", frame_count, 4);
    chk("end_fdata",  frame_data, 30'b110_111_001_010);
    chk("end_not_yet", test_has_ended, 0);
    frame_ready = 1'b1;
    tick();
    chk("end_ended",  test_has_ended, 1);
    chk("end_fvalid_lo", frame_valid, 0);
    chk("end_count", dct_count, 0);
    frame_ready    = 1'b0;
    addr_sym_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_sticky",   test_has_ended, 1);
      chk("done_addr_rdy", addr_sym_ready, 0);
    end
    addr_sym_valid = 1'b0;

    // Reset out of DONE, fill 2 symbols, idle into EMIT, then reset mid-cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_ended", test_has_ended, 0);
    addr_sym_valid = 1'b1;
    addr_sym = 3'd1; tick();
    addr_sym = 3'd2; tick();
    addr_sym_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("rst2_fvalid", frame_valid, 1);
    chk("rst2_fcount", frame_count, 2);
    addr_sym_valid = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("async_fvalid",  frame_valid, 0);
    chk("async_count",   dct_count, 0);
    chk("async_buffer",  dct_buffer, 0);
    chk("async_fcount",  frame_count, 0);
    chk("async_addr_rdy", addr_sym_ready, 0);
    #2;
    reset    = 1'b0;
    addr_sym = 3'd7;
    #1;
    chk("post_rst_addr_rdy", addr_sym_ready, 1);
    chk("post_rst_ended",    test_has_ended, 0);
    chk("post_rst_count",    dct_count, 0);
    tick();
    chk("post_rst_acc_count", dct_count, 1);
    chk("post_rst_acc_buf",   dct_buffer, 30'b111);
    addr_sym_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oci_dct_sequencer.md
# oci_dct_sequencer

Sequencer for the CPU OCI data-capture-trace (DCT) buffer. It round-robin arbitrates between an address-trace and a data-trace symbol source and packs 3-bit symbols into the 30-bit `dct_buffer` with a symbol count in `dct_count`. It emits each full or flushed buffer as a frame over a valid/ready handshake, and sequences end-of-test draining so that `test_has_ended` is asserted only after all captured trace has left the block. It sits between the OCI trace sources and the trace frame sink or test-bench monitor.

## Interface
- `IDLE_FLUSH`, default 64: idle cycles with a partial buffer before a forced flush; 0 disables the idle flush.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr_sym_valid` in 1: address-trace symbol offered.
- `addr_sym` in 3: address-trace symbol.
- `addr_sym_ready` out 1: address symbol accepted this cycle.
- `data_sym_valid` in 1: data-trace symbol offered.
- `data_sym` in 3: data-trace symbol.
- `data_sym_ready` out 1: data symbol accepted this cycle.
- `test_ending` in 1: level request to drain and stop.
- `frame_valid` out 1: frame available.
- `frame_ready` in 1: sink accepts the frame.
- `frame_data` out 30: frame contents; equals `dct_buffer` while `frame_valid` is high.
- `frame_count` out 4: valid symbols in the frame, 1..10.
- `dct_buffer` out 30: live packing register.
- `dct_count` out 4: live symbol count, 0..10.
- `test_has_ended` out 1: drain complete (sticky).

## Operation
- States: FILL, EMIT, DONE. Reset places the block in FILL with `dct_buffer`=0, `dct_count`=0, the idle counter at 0 and `last_grant`=DATA.
- All outputs are 0 while `reset` is asserted.
- Arbitration, FILL only, and only when `test_ending`=0:
  - Only one source valid: that source is granted.
  - Both sources valid: the source other than `last_grant` is granted. The first contest after reset therefore goes to addr.
  - `last_grant` updates on every accept.
- Readies: `*_sym_ready` = grant. Ready is combinational from the valids, `test_ending` and the state, and at most one ready is high per cycle.
- Accept behaviour: `dct_buffer` <= {`dct_buffer`[26:0], sym} and `dct_count` += 1.
  - The newest symbol is in [2:0] and the oldest is at [3·count−1 : 3·count−3].
  - Unused upper bits stay 0.
- Idle counter:
  - Increments in FILL when `dct_count`>0 and no symbol is accepted.
  - Clears on any accept and on leaving FILL.
- FILL exits:
  - Accept with `dct_count`=9 goes to EMIT.
  - Idle counter reaching `IDLE_FLUSH`−1 while not accepting goes to EMIT. This requires `IDLE_FLUSH`≠0.
  - `test_ending`=1 with `dct_count`>0 goes to EMIT and latches `ending_pend`.
  - `test_ending`=1 with `dct_count`=0 goes to DONE.
- EMIT:
  - `frame_valid`=1 and both readies are 0.
  - `frame_data` and `frame_count` are held stable until the handshake.
  - When `test_ending` is asserted in EMIT, `ending_pend` is latched.
  - On `frame_valid`&`frame_ready`, `dct_buffer` and `dct_count` clear to 0. The next state is DONE if `ending_pend` or `test_ending`, otherwise FILL.
- DONE: `test_has_ended`=1, readies 0, `frame_valid` 0. The block stays in DONE until reset; deasserting `test_ending` has no effect.
- Count never exceeds 10. A frame with `frame_count`=0 is never emitted.

## Timing
- Accept-to-register latency is 1 cycle. `dct_count` shows the new value in the cycle after the handshake.
- The 10th accept is at edge N and `frame_valid` rises at edge N. A frame therefore appears one cycle after the cycle containing the 10th handshake.
- `frame_ready` may be high before `frame_valid`. The handshake completes in the first EMIT cycle, and FILL accepts again in the following cycle. Minimum frame period is 11 cycles.
- With one source continuously valid, throughput is 1 symbol/cycle in FILL. With both sources valid, they alternate A, D, A, D…
- An idle flush fires exactly `IDLE_FLUSH` non-accepting FILL cycles after the last accept.
- `test_ending` and a valid symbol in the same cycle: the symbol is not accepted, and `test_ending` takes priority.
- `test_has_ended` rises the edge after the final frame handshake, or the edge after `test_ending` when the buffer is empty.
- Reset mid-EMIT drops the frame, with no partial handshake. All state returns to its reset values asynchronously.

## Test plan
- Addr only, symbols 1..10 back-to-back → after 10 accepts, `frame_valid`=1, `frame_count`=10, `frame_data`=0b001_010_011_100_101_110_111_000_001_010 (sym&7); `dct_count`=0 after the handshake.
- Both sources always valid, addr=5, data=2 → accepts alternate A, D starting with A; frame = 5,2,5,2,…; each ready is high on alternate cycles only.
- 3 symbols then idle, `IDLE_FLUSH`=4 → `frame_valid` 4 cycles after the last accept, `frame_count`=3, `frame_data`[29:9]=0.
- `frame_ready` held 0 for 20 cycles in EMIT → `frame_data` stable, both readies 0; release → FILL one cycle later.
- 4 symbols, then `test_ending` pulsed for 1 cycle with a valid symbol present → symbol not accepted, frame `frame_count`=4; after the handshake `test_has_ended`=1 and stays 1.
- Async `reset` asserted mid-EMIT, between clock edges → outputs 0 immediately; after release, state is FILL, `dct_count`=0 and `test_has_ended`=0.
